// File: rtl/responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : responder_pkg
// Description : Shared types and helpers for the burst bus responder: the
//               responder state encoding, the arbitration priority type and
//               the burst range check used before granting a request.
// Revision    : 1.0 - initial release
// ============================================================================
package responder_pkg;

  localparam int unsigned RSP_DATA_W = 32;
  localparam int unsigned RSP_ADDR_W = 32;

  // Responder FSM states.
  typedef enum logic [1:0] {
    RSP_IDLE     = 2'd0,
    RSP_RD_BURST = 2'd1,
    RSP_WR_BURST = 2'd2,
    RSP_ERROR    = 2'd3
  } resp_state_t;

  // Which request type wins the next simultaneous read/write contest.
  typedef enum logic {
    PRIO_READ  = 1'b0,
    PRIO_WRITE = 1'b1
  } resp_prio_t;

  // True when a burst of len words starting at addr stays inside a store of
  // depth words. Compared against depth-len so the sum can never overflow.
  function automatic logic burst_fits(input logic [RSP_ADDR_W-1:0] addr,
                                      input int unsigned depth,
                                      input int unsigned len);
    if (len > depth) begin
      return 1'b0;
    end
    return (addr <= 32'(depth - len));
  endfunction

endpackage
`default_nettype wire

// File: rtl/responder_mem.sv
`default_nettype none
// ============================================================================
// Module      : responder_mem
// Description : Backing store for the bus responder. DEPTH x WIDTH array with
//               one synchronous write port and one combinational read port.
//               Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module responder_mem #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 6
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Single write port, committed on the rising edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Asynchronous read so the responder can register the beat in one cycle.
  assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : bus_responder
// Description : Burst read/write responder in front of a word-addressed
//               memory. Round-robin arbitration between read and write
//               requests, range-checked bursts, abort on request drop.
//               Optional macro RESP_WAIT_STATE_EN inserts one wait cycle
//               between a grant and the first read beat / first accepted
//               write beat.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_responder
  import responder_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 64,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        read_request,
  input  logic [31:0] read_addr,
  output logic        read_gnt,
  output logic        read_valid,
  output logic [31:0] read_data,
  input  logic        write_request,
  input  logic [31:0] write_addr,
  input  logic        write_valid,
  input  logic [31:0] write_data,
  output logic        write_gnt,
  output logic        bus_error
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned BW = $clog2(BURST_LEN) + 1;
  localparam logic [BW-1:0] BEATS     = BW'(BURST_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

`ifdef RESP_WAIT_STATE_EN
  localparam logic WAIT_EN = 1'b1;
`else
  localparam logic WAIT_EN = 1'b0;
`endif

  resp_state_t     state;
  resp_prio_t      prio;
  logic [BW-1:0]   beat;
  logic [AW-1:0]   base;
  logic            wait_pend;

  logic            read_fits;
  logic            write_fits;
  logic            pick_read;
  logic            pick_write;

  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [31:0]     mem_rdata;

  // Arbitration and range check for the request presented in idle.
  always_comb begin
    read_fits  = burst_fits(read_addr, MEM_DEPTH, BURST_LEN);
    write_fits = burst_fits(write_addr, MEM_DEPTH, BURST_LEN);
    pick_read  = read_request && (!write_request || (prio == PRIO_READ));
    pick_write = write_request && !pick_read;
  end

  // Bursts are range-checked at grant, so base + beat never wraps.
  assign mem_addr = base + AW'(beat);

  // A write beat is taken only in the write burst, outside the grant cycle
  // and any wait cycle, while the initiator still holds its request.
  assign mem_we = (state == RSP_WR_BURST) && write_request && write_valid &&
                  !write_gnt && !wait_pend;

  responder_mem #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (32),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (mem_addr),
    .wr_data (write_data),
    .rd_addr (mem_addr),
    .rd_data (mem_rdata)
  );

  // Responder FSM with registered grant, beat and error outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RSP_IDLE;
      prio       <= PRIO_READ;
      beat       <= '0;
      base       <= '0;
      wait_pend  <= 1'b0;
      read_gnt   <= 1'b0;
      write_gnt  <= 1'b0;
      read_valid <= 1'b0;
      read_data  <= '0;
      bus_error  <= 1'b0;
    end else begin
      // Pulses by default; set below only in the cycle they apply.
      read_gnt   <= 1'b0;
      write_gnt  <= 1'b0;
      read_valid <= 1'b0;
      bus_error  <= 1'b0;

      unique case (state)
        RSP_IDLE: begin
          beat <= '0;
          if (pick_read) begin
            if (read_fits) begin
              state     <= RSP_RD_BURST;
              read_gnt  <= 1'b1;
              base      <= read_addr[AW-1:0];
              wait_pend <= WAIT_EN;
              prio      <= PRIO_WRITE;
            end else begin
              state     <= RSP_ERROR;
              bus_error <= 1'b1;
            end
          end else if (pick_write) begin
            if (write_fits) begin
              state     <= RSP_WR_BURST;
              write_gnt <= 1'b1;
              base      <= write_addr[AW-1:0];
              wait_pend <= WAIT_EN;
              prio      <= PRIO_READ;
            end else begin
              state     <= RSP_ERROR;
              bus_error <= 1'b1;
            end
          end
        end

        RSP_RD_BURST: begin
          if (!read_request) begin
            // Initiator gave up: stop driving beats immediately.
            state <= RSP_IDLE;
          end else if (wait_pend) begin
            wait_pend <= 1'b0;
          end else if (beat == BEATS) begin
            // Last beat was on the bus this cycle; leave without re-granting.
            state <= RSP_IDLE;
          end else begin
            read_valid <= 1'b1;
            read_data  <= mem_rdata;
            beat       <= beat + 1'b1;
          end
        end

        RSP_WR_BURST: begin
          if (!write_request) begin
            state <= RSP_IDLE;
          end else if (write_gnt) begin
            // Grant cycle: the initiator has not yet seen the grant.
            beat <= '0;
          end else if (wait_pend) begin
            wait_pend <= 1'b0;
          end else if (write_valid) begin
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) begin
              state <= RSP_IDLE;
            end
          end
        end

        RSP_ERROR: begin
          state <= RSP_IDLE;
        end

        default: begin
          state <= RSP_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_responder
// Description : Directed self-checking bench for bus_responder: reset values,
//               read/write bursts, write stalls, round-robin arbitration,
//               range errors, request abort and reset mid-burst.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_responder;

  localparam int unsigned MEM_DEPTH = 64;
  localparam int unsigned BURST_LEN = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        read_request;
  logic [31:0] read_addr;
  logic        read_gnt;
  logic        read_valid;
  logic [31:0] read_data;
  logic        write_request;
  logic [31:0] write_addr;
  logic        write_valid;
  logic [31:0] write_data;
  logic        write_gnt;
  logic        bus_error;

  int checks = 0;
  int errors = 0;

  logic [31:0] pat_a   [4];
  logic [31:0] pat_d   [4];
  logic [31:0] pat_e   [4];
  logic [31:0] pat_f   [4];
  logic [31:0] pat_g   [4];
  logic [31:0] pat_h   [4];
  logic [31:0] pat_j   [4];
  logic [31:0] pat_k   [4];
  logic [31:0] exp_rst [4];

  always #5 clk = ~clk;

  bus_responder #(
    .MEM_DEPTH (MEM_DEPTH),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .read_request  (read_request),
    .read_addr     (read_addr),
    .read_gnt      (read_gnt),
    .read_valid    (read_valid),
    .read_data     (read_data),
    .write_request (write_request),
    .write_addr    (write_addr),
    .write_valid   (write_valid),
    .write_data    (write_data),
    .write_gnt     (write_gnt),
    .bus_error     (bus_error)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_rgnt"},  32'(read_gnt),   32'd0);
    check_val({tag, "_wgnt"},  32'(write_gnt),  32'd0);
    check_val({tag, "_rval"},  32'(read_valid), 32'd0);
    check_val({tag, "_berr"},  32'(bus_error),  32'd0);
    check_val({tag, "_rdata"}, read_data,       32'd0);
  endtask

  // Wait (bounded) for a grant; it must arrive exactly one cycle later.
  task automatic wait_gnt(input logic want_read, input string tag);
    int lat = 0;
    do begin
      tick();
      lat++;
    end while (((want_read ? read_gnt : write_gnt) !== 1'b1) && (lat < 8));
    check_val({tag, "_gnt_lat"}, 32'(lat), 32'd1);
  endtask

  // Called in the grant cycle of a read burst.
  task automatic rd_data_phase(input string tag, input logic [31:0] exp [4]);
`ifdef RESP_WAIT_STATE_EN
    tick();
    check_val({tag, "_wait_val"}, 32'(read_valid), 32'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val({tag, "_valid"}, 32'(read_valid), 32'd1);
      check_val({tag, "_data"}, read_data, exp[i]);
      if (i == 0) check_val({tag, "_gnt_pulse"}, 32'(read_gnt), 32'd0);
    end
    read_request = 1'b0;
    tick();
    check_val({tag, "_end_val"}, 32'(read_valid), 32'd0);
  endtask

  // Called in the grant cycle of a write burst; stall cycles follow beat 1.
  task automatic wr_data_phase(input string tag, input logic [31:0] d [4], input int stall);
    tick();
    check_val({tag, "_gnt_pulse"}, 32'(write_gnt), 32'd0);
`ifdef RESP_WAIT_STATE_EN
    tick();
`endif
    for (int i = 0; i < 4; i++) begin
      write_valid = 1'b1;
      write_data  = d[i];
      tick();
      if (i == 1) begin
        write_valid = 1'b0;
        repeat (stall) tick();
      end
    end
    write_valid   = 1'b0;
    write_request = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] d [4], input int stall, input string tag);
    write_request = 1'b1;
    write_addr    = addr;
    wait_gnt(1'b0, tag);
    wr_data_phase(tag, d, stall);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp [4], input string tag);
    read_request = 1'b1;
    read_addr    = addr;
    wait_gnt(1'b1, tag);
    rd_data_phase(tag, exp);
  endtask

  // Both requests raised in the same cycle; read_first is the expected winner.
  task automatic arb_both(input logic [31:0] raddr, input logic [31:0] rexp [4],
                          input logic [31:0] waddr, input logic [31:0] wd [4],
                          input logic read_first, input string tag);
    read_request  = 1'b1;
    read_addr     = raddr;
    write_request = 1'b1;
    write_addr    = waddr;
    if (read_first) begin
      wait_gnt(1'b1, {tag, "_r1"});
      check_val({tag, "_r1_no_wgnt"}, 32'(write_gnt), 32'd0);
      rd_data_phase({tag, "_r1"}, rexp);
      wait_gnt(1'b0, {tag, "_w2"});
      wr_data_phase({tag, "_w2"}, wd, 0);
    end else begin
      wait_gnt(1'b0, {tag, "_w1"});
      check_val({tag, "_w1_no_rgnt"}, 32'(read_gnt), 32'd0);
      wr_data_phase({tag, "_w1"}, wd, 0);
      wait_gnt(1'b1, {tag, "_r2"});
      rd_data_phase({tag, "_r2"}, rexp);
    end
  endtask

  task automatic do_error(input logic is_read, input logic [31:0] addr, input string tag);
    if (is_read) begin
      read_request = 1'b1;
      read_addr    = addr;
    end else begin
      write_request = 1'b1;
      write_addr    = addr;
    end
    tick();
    check_val({tag, "_berr"}, 32'(bus_error), 32'd1);
    check_val({tag, "_gnt"}, 32'(is_read ? read_gnt : write_gnt), 32'd0);
    read_request  = 1'b0;
    write_request = 1'b0;
    tick();
    check_val({tag, "_berr_pulse"}, 32'(bus_error), 32'd0);
    check_val({tag, "_gnt2"}, 32'(is_read ? read_gnt : write_gnt), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      pat_a[i] = 32'hA000_0000 + i;
      pat_d[i] = 32'hD00D_0000 + i;
      pat_e[i] = 32'hE000_1110 + i;
      pat_f[i] = 32'hF0F0_0000 + i;
      pat_g[i] = 32'h6060_0000 + i;
      pat_h[i] = 32'h1234_5600 + i;
      pat_j[i] = 32'h3A3A_0000 + i;
      pat_k[i] = 32'h5C5C_0000 + i;
    end
    exp_rst[0] = pat_k[0];
    exp_rst[1] = pat_j[1];
    exp_rst[2] = pat_j[2];
    exp_rst[3] = pat_j[3];

    reset_n       = 1'b1;
    read_request  = 1'b0;
    read_addr     = '0;
    write_request = 1'b0;
    write_addr    = '0;
    write_valid   = 1'b0;
    write_data    = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    reset_n = 1'b1;

    // Preload mem[8..11], then read/write contest twice: read wins both.
    do_write(32'd8, pat_a, 0, "wr8");
    arb_both(32'd8,  pat_a, 32'd20, pat_e, 1'b1, "arb1");
    arb_both(32'd20, pat_e, 32'd24, pat_f, 1'b1, "arb2");

    // Write with two stall cycles after beat 1, then read it back.
    do_write(32'd0, pat_d, 2, "wr0_stall");
    do_read(32'd0, pat_d, "rd0");

    // Read was granted last, so write wins the next contest.
    arb_both(32'd24, pat_f, 32'd28, pat_g, 1'b0, "arb3");
    do_read(32'd28, pat_g, "rd28");

    // Range boundary: 60 fits exactly, 61/62 are rejected.
    do_error(1'b1, 32'd62, "rd62");
    do_error(1'b0, 32'd61, "wr61");
    do_error(1'b1, 32'hFFFF_FFFE, "rd_huge");
    do_write(32'd60, pat_h, 0, "wr60");
    do_read(32'd60, pat_h, "rd60");

    // Read abort after beat 1.
    read_request = 1'b1;
    read_addr    = 32'd8;
    wait_gnt(1'b1, "rd_abort");
`ifdef RESP_WAIT_STATE_EN
    tick();
`endif
    tick();
    check_val("rd_abort_b0", read_data, pat_a[0]);
    tick();
    check_val("rd_abort_b1", read_data, pat_a[1]);
    read_request = 1'b0;
    tick();
    check_val("rd_abort_val", 32'(read_valid), 32'd0);
    tick();
    check_val("rd_abort_val2", 32'(read_valid), 32'd0);

    // Reset mid write burst: only beat 0 lands.
    do_write(32'd32, pat_j, 0, "wr32");
    write_request = 1'b1;
    write_addr    = 32'd32;
    wait_gnt(1'b0, "rst_wr");
    tick();
`ifdef RESP_WAIT_STATE_EN
    tick();
`endif
    write_valid = 1'b1;
    write_data  = pat_k[0];
    tick();
    write_data  = pat_k[1];
    reset_n     = 1'b0;
    tick();
    check_quiet("rst_mid");
    write_valid   = 1'b0;
    write_request = 1'b0;
    reset_n       = 1'b1;
    do_read(32'd32, exp_rst, "rd32_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 64, number of 32-bit words in the backing store (power of two).
REQ-002 SHALL have parameter BURST_LEN, default 4, number of beats per read or write burst.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port read_request  input  1  initiator requests a read burst; held high until the burst completes.
REQ-006 SHALL have port read_addr  input  32  word address of the first read beat; sampled at grant.
REQ-007 SHALL have port read_gnt  output  1  high for exactly one cycle when the read burst is accepted.
REQ-008 SHALL have port read_valid  output  1  read_data carries a valid beat.
REQ-009 SHALL have port read_data  output  32  read beat data.
REQ-010 SHALL have port write_request  input  1  initiator requests a write burst; held high until the burst completes.
REQ-011 SHALL have port write_addr  input  32  word address of the first write beat; sampled at grant.
REQ-012 SHALL have port write_valid  input  1  write_data carries a valid beat.
REQ-013 SHALL have port write_data  input  32  write beat data.
REQ-014 SHALL have port write_gnt  output  1  high for exactly one cycle when the write burst is accepted.
REQ-015 SHALL have port bus_error  output  1  one-cycle pulse on a rejected request.

Function
REQ-016 SHALL implement states RSP_IDLE, RSP_RD_BURST, RSP_WR_BURST and RSP_ERROR.
REQ-017 In RSP_IDLE with exactly one request high, SHALL assert the matching gnt the next cycle and enter the matching burst state.
REQ-018 With both requests high in RSP_IDLE, SHALL grant the type not granted most recently (round-robin); after reset, read wins.
REQ-019 In RSP_RD_BURST, SHALL drive read_valid high for BURST_LEN consecutive cycles starting the cycle after read_gnt, with beat n returning mem[read_addr+n], then return to RSP_IDLE.
REQ-020 In RSP_WR_BURST, SHALL write write_data to mem[write_addr+n] on each cycle write_valid is high (beat counter advances only then); write_valid low stalls without timeout; SHALL return to RSP_IDLE after beat BURST_LEN-1.
REQ-021 A request with start address + BURST_LEN > MEM_DEPTH SHALL produce no gnt; SHALL enter RSP_ERROR for one cycle with bus_error=1, then return to RSP_IDLE; no wrap-around.
REQ-022 Request deasserted mid-burst SHALL abort: next cycle RSP_IDLE, read_valid=0, no further memory writes; beats already written are kept.
REQ-023 Beat counter SHALL be clog2(BURST_LEN)+1 bits; address arithmetic SHALL be 32-bit unsigned.
REQ-024 A new request SHALL NOT be granted in the same cycle a burst ends; earliest new gnt is one cycle after return to RSP_IDLE.

Reset
REQ-025 On reset_n low: state RSP_IDLE; read_gnt, write_gnt, read_valid, bus_error = 0; read_data = 0; beat counter 0; round-robin pointer = read; memory contents undefined.
REQ-026 Reset asserted mid-burst SHALL abort immediately with no further memory writes.

Configuration
REQ-027 With RESP_WAIT_STATE_EN defined, SHALL insert one wait cycle between gnt and the first read beat / first accepted write beat (write_valid ignored in that cycle); without it, timing is per REQ-019/020.

Structure
REQ-028 resp_state_t (2-bit enum of the four states) SHALL live in shared package responder_pkg, alongside the existing read/write/dma state packages.
REQ-029 Storage SHALL be sub-module responder_mem: MEM_DEPTH x 32, one synchronous write port, one combinational read port.

Verification
REQ-030 Read at addr 8 after preloading mem[8..11]=A0..A3 -> read_gnt 1 cycle later, A0..A3 on 4 consecutive cycles.
REQ-031 Write at addr 0 with D0..D3 and write_valid low for 2 cycles after beat 1 -> all 4 words stored, burst ends 2 cycles late.
REQ-032 Read and write requested in the same cycle, twice -> read granted first, then write.
REQ-033 Read at addr 62 (MEM_DEPTH 64) -> no read_gnt, bus_error pulses exactly 1 cycle.
REQ-034 Write burst with reset_n low after beat 1 -> only beat 0 stored, all outputs 0 next edge.
REQ-035 With RESP_WAIT_STATE_EN, read at addr 0 -> first read_valid 2 cycles after read_gnt.
